// File: rtl/vm_credit_fsm.sv
// Credit-accumulating vending controller with one-UNIT-per-beat change return.
// Optional refund request port enabled by defining VM_CANCEL_EN.
module vm_credit_fsm #(
    parameter int CREDIT_W = 8,
    parameter int PRICE    = 10,
    parameter int UNIT     = 5,
    parameter int V1       = 5,
    parameter int V2       = 10,
    parameter int V3       = 20
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          cash_in,
`ifdef VM_CANCEL_EN
    input  logic                cancel,
`endif
    input  logic                chg_ready,
    output logic                purchase,
    output logic                chg_valid,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    localparam logic [CREDIT_W:0]   MAX_W   = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(UNIT);

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n;
    logic                rej_q, rej_n;
    logic [CREDIT_W:0]   coin_v;
    logic [CREDIT_W:0]   sum;
    logic                coin;
    logic                cancel_req;

    assign coin = (cash_in != 2'b00);

`ifdef VM_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    always_comb begin
        coin_v = '0;
        unique case (cash_in)
            2'b01:   coin_v = (CREDIT_W+1)'(V1);
            2'b10:   coin_v = (CREDIT_W+1)'(V2);
            2'b11:   coin_v = (CREDIT_W+1)'(V3);
            default: coin_v = '0;
        endcase
    end

    // One extra bit so an overflowing coin is detected rather than wrapped.
    assign sum = {1'b0, credit_q} + coin_v;

    always_comb begin
        state_n  = state;
        credit_n = credit_q;
        rej_n    = 1'b0;
        unique case (state)
            S_IDLE, S_COLLECT: begin
                if (state == S_COLLECT && cancel_req) begin
                    state_n = S_CHANGE;
                    rej_n   = coin;
                end else if (coin) begin
                    if (sum > MAX_W) begin
                        rej_n = 1'b1;
                    end else begin
                        credit_n = sum[CREDIT_W-1:0];
                        state_n  = (sum >= PRICE_W) ? S_VEND : S_COLLECT;
                    end
                end
            end
            S_VEND: begin
                rej_n    = coin;
                credit_n = credit_q - PRICE_C;
                state_n  = (credit_n != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                rej_n = coin;
                if (chg_ready) begin
                    credit_n = credit_q - UNIT_C;
                    if (credit_n == '0) state_n = S_IDLE;
                end
            end
            default: begin
                state_n  = S_IDLE;
                credit_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            credit_q <= '0;
            rej_q    <= 1'b0;
        end else begin
            state    <= state_n;
            credit_q <= credit_n;
            rej_q    <= rej_n;
        end
    end

    assign purchase    = (state == S_VEND);
    assign chg_valid   = (state == S_CHANGE);
    assign busy        = (state == S_VEND) || (state == S_CHANGE);
    assign coin_reject = rej_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_vm_credit_fsm.sv
// Directed bench for vm_credit_fsm: default instance plus a narrow-credit
// instance for the overflow-reject case.
module tb_vm_credit_fsm;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] cash_a, cash_b;
    logic       rdy_a, rdy_b;
    logic       cancel_a, cancel_b;
    logic       pur_a, cv_a, rej_a, busy_a;
    logic       pur_b, cv_b, rej_b, busy_b;
    logic [7:0] cr_a;
    logic [4:0] cr_b;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    vm_credit_fsm u_a (
        .clk         (clk),
        .rstn        (rstn),
        .cash_in     (cash_a),
`ifdef VM_CANCEL_EN
        .cancel      (cancel_a),
`endif
        .chg_ready   (rdy_a),
        .purchase    (pur_a),
        .chg_valid   (cv_a),
        .coin_reject (rej_a),
        .credit      (cr_a),
        .busy        (busy_a)
    );

    vm_credit_fsm #(.CREDIT_W(5), .PRICE(40)) u_b (
        .clk         (clk),
        .rstn        (rstn),
        .cash_in     (cash_b),
`ifdef VM_CANCEL_EN
        .cancel      (cancel_b),
`endif
        .chg_ready   (rdy_b),
        .purchase    (pur_b),
        .chg_valid   (cv_b),
        .coin_reject (rej_b),
        .credit      (cr_b),
        .busy        (busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs of instance A packed as {purchase, chg_valid, coin_reject, busy}
    function automatic int flags_a();
        return int'({pur_a, cv_a, rej_a, busy_a});
    endfunction

    initial begin
        rstn = 1'b0; cash_a = 2'b00; cash_b = 2'b00;
        rdy_a = 1'b1; rdy_b = 1'b1; cancel_a = 1'b0; cancel_b = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        chk("rst_credit", int'(cr_a), 0);
        chk("rst_flags", flags_a(), 0);
        chk("rst_credit_b", int'(cr_b), 0);

        // 1: two 5 TK coins, exact price
        cash_a = 2'b01; tick();
        chk("t1_credit5", int'(cr_a), 5);
        chk("t1_flags_collect", flags_a(), 4'b0000);
        tick();
        chk("t1_credit10", int'(cr_a), 10);
        chk("t1_vend_flags", flags_a(), 4'b1001);
        cash_a = 2'b00; tick();
        chk("t1_credit0", int'(cr_a), 0);
        chk("t1_idle_flags", flags_a(), 4'b0000);

        // 2: 20 TK coin, two change beats
        cash_a = 2'b11; tick();
        cash_a = 2'b00;
        chk("t2_credit20", int'(cr_a), 20);
        chk("t2_vend_flags", flags_a(), 4'b1001);
        tick();
        chk("t2_credit10", int'(cr_a), 10);
        chk("t2_chg_flags1", flags_a(), 4'b0101);
        tick();
        chk("t2_credit5", int'(cr_a), 5);
        chk("t2_chg_flags2", flags_a(), 4'b0101);
        tick();
        chk("t2_credit0", int'(cr_a), 0);
        chk("t2_idle_flags", flags_a(), 4'b0000);

        // 3: hopper stalls, coin during change rejected
        rdy_a = 1'b0;
        cash_a = 2'b11; tick();
        cash_a = 2'b00; tick();
        chk("t3_chg_credit10", int'(cr_a), 10);
        cash_a = 2'b01; tick();
        cash_a = 2'b00;
        chk("t3_rej_flags", flags_a(), 4'b0111);
        chk("t3_rej_credit", int'(cr_a), 10);
        tick();
        chk("t3_rej_pulse_end", flags_a(), 4'b0101);
        tick(); tick();
        chk("t3_held_credit", int'(cr_a), 10);
        chk("t3_held_flags", flags_a(), 4'b0101);
        rdy_a = 1'b1; tick();
        chk("t3_beat1", int'(cr_a), 5);
        tick();
        chk("t3_beat2", int'(cr_a), 0);
        chk("t3_idle_flags", flags_a(), 4'b0000);

        // 4: narrow instance overflow
        cash_b = 2'b11; tick();
        chk("t4_credit20", int'(cr_b), 20);
        cash_b = 2'b10; tick();
        chk("t4_credit30", int'(cr_b), 30);
        cash_b = 2'b01; tick();
        cash_b = 2'b00;
        chk("t4_reject", int'(rej_b), 1);
        chk("t4_credit_kept", int'(cr_b), 30);
        chk("t4_no_purchase", int'(pur_b), 0);
        tick();
        chk("t4_reject_end", int'(rej_b), 0);
        chk("t4_credit_still", int'(cr_b), 30);

        // 5: reset mid-change, coindropped on the reset edge
        cash_a = 2'b11; tick();
        cash_a = 2'b00; tick();
        chk("t5_pre_credit", int'(cr_a), 10);
        chk("t5_pre_flags", flags_a(), 4'b0101);
        rstn = 1'b0; cash_a = 2'b10; tick();
        rstn = 1'b1; cash_a = 2'b00;
        chk("t5_rst_credit", int'(cr_a), 0);
        chk("t5_rst_flags", flags_a(), 4'b0000);
        cash_a = 2'b10; tick();
        cash_a = 2'b00;
        chk("t5_vend_credit", int'(cr_a), 10);
        chk("t5_vend_flags", flags_a(), 4'b1001);
        tick();
        chk("t5_after_credit", int'(cr_a), 0);
        chk("t5_after_flags", flags_a(), 4'b0000);

`ifdef VM_CANCEL_EN
        // 6: refund from COLLECT, then cancel in IDLE
        cash_a = 2'b01; tick();
        cash_a = 2'b00;
        chk("t6_credit5", int'(cr_a), 5);
        cancel_a = 1'b1; tick();
        cancel_a = 1'b0;
        chk("t6_refund_flags", flags_a(), 4'b0101);
        chk("t6_refund_credit", int'(cr_a), 5);
        tick();
        chk("t6_done_credit", int'(cr_a), 0);
        chk("t6_done_flags", flags_a(), 4'b0000);
        cancel_a = 1'b1; tick();
        cancel_a = 1'b0;
        chk("t6_idle_cancel", flags_a(), 4'b0000);
        chk("t6_idle_credit", int'(cr_a), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
